// File: rtl/router_pkg.sv
// Shared router constants and the header address type.
package router_pkg;

  localparam int unsigned DEF_NUM_CH  = 3;
  localparam int unsigned DEF_TIMEOUT = 30;
  localparam int unsigned DEF_ADDR_W  = 2;

  typedef logic [DEF_ADDR_W-1:0] router_addr_t;

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel stall watchdog: pulses soft_reset for one cycle after TIMEOUT
// consecutive cycles of valid data that nobody reads.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             stall;

  assign stall = vld & ~rd;

  // A read on the threshold cycle clears the count, so it also suppresses the pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (stall) begin
      if (cnt == LAST) begin
        cnt        <= '0;
        soft_reset <= 1'b1;
      end else begin
        cnt        <= cnt + CNT_W'(1);
        soft_reset <= 1'b0;
      end
    end else begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the header destination, steers the FIFO write
// enable, and flushes channels whose data sits unread for too long.
module router_sync_n
  import router_pkg::*;
#(
  parameter int unsigned NUM_CH  = DEF_NUM_CH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] datain,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);

  logic [ADDR_W-1:0] dest;
  logic              dest_valid;
  logic              addr_ok;

  assign addr_ok = 32'(datain) < NUM_CH;
  assign vld_out = ~empty;

  // A bad header invalidates the route but leaves the last dest value in place.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dest       <= '0;
      dest_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      if (detect_add) begin
        if (addr_ok) begin
          dest       <= datain;
          dest_valid <= 1'b1;
        end else begin
          dest_valid <= 1'b0;
          addr_err   <= 1'b1;
        end
      end
    end
  end

  // Decoded by comparison so ADDR_W may be wider than the channel index.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (dest_valid && (32'(dest) == i)) begin
        fifo_full    = full[i];
        write_enb[i] = write_enb_reg & ~soft_reset[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT(TIMEOUT)
    ) u_timer (
      .clk       (clk),
      .resetn    (resetn),
      .vld       (vld_out[g]),
      .rd        (read_enb[g]),
      .soft_reset(soft_reset[g])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed self-checking bench for router_sync_n with default parameters.
module tb_router_sync_n;

  localparam int unsigned NUM_CH  = 3;
  localparam int unsigned TIMEOUT = 30;
  localparam int unsigned ADDR_W  = 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic              detect_add;
  logic [ADDR_W-1:0] datain;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic [NUM_CH-1:0] soft_reset;
  logic              addr_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  router_sync_n #(
    .NUM_CH (NUM_CH),
    .TIMEOUT(TIMEOUT),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .detect_add   (detect_add),
    .datain       (datain),
    .write_enb_reg(write_enb_reg),
    .read_enb     (read_enb),
    .empty        (empty),
    .full         (full),
    .vld_out      (vld_out),
    .write_enb    (write_enb),
    .fifo_full    (fifo_full),
    .soft_reset   (soft_reset),
    .addr_err     (addr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn        = 1'b0;
    detect_add    = 1'b1;
    datain        = 2'd1;
    write_enb_reg = 1'b1;
    read_enb      = '0;
    empty         = 3'b010;
    full          = '1;
    tick(); tick(); tick();

    // reset state; vld_out follows empty during reset
    check("rst_soft_reset", 32'(soft_reset), 32'h0);
    check("rst_addr_err",   32'(addr_err),   32'h0);
    check("rst_write_enb",  32'(write_enb),  32'h0);
    check("rst_fifo_full",  32'(fifo_full),  32'h0);
    check("rst_vld_out",    32'(vld_out),    32'h5);

    detect_add    = 1'b0;
    write_enb_reg = 1'b0;
    empty         = '1;
    tick();
    resetn = 1'b1;
    tick();

    // address decode: dest 2
    detect_add    = 1'b1;
    datain        = 2'd2;
    write_enb_reg = 1'b1;
    #1;
    check("dec_we_same_cycle", 32'(write_enb), 32'h0);
    tick();
    detect_add = 1'b0;
    full       = 3'b100;
    #1;
    check("dec_write_enb",   32'(write_enb), 32'h4);
    check("dec_fifo_full_1", 32'(fifo_full), 32'h1);
    check("dec_addr_err",    32'(addr_err),  32'h0);
    full = 3'b011;
    #1;
    check("dec_fifo_full_0", 32'(fifo_full), 32'h0);
    tick();
    check("dec_hold", 32'(write_enb), 32'h4);

    // bad address 3
    detect_add = 1'b1;
    datain     = 2'd3;
    full       = '1;
    tick();
    detect_add = 1'b0;
    #1;
    check("bad_addr_err",  32'(addr_err),  32'h1);
    check("bad_write_enb", 32'(write_enb), 32'h0);
    check("bad_fifo_full", 32'(fifo_full), 32'h0);
    tick();
    check("bad_addr_err_end", 32'(addr_err),  32'h0);
    check("bad_hold_invalid", 32'(write_enb), 32'h0);

    // relatch dest 0
    detect_add = 1'b1;
    datain     = 2'd0;
    tick();
    detect_add = 1'b0;
    full       = 3'b001;
    #1;
    check("dec0_write_enb", 32'(write_enb), 32'h1);
    check("dec0_fifo_full", 32'(fifo_full), 32'h1);
    write_enb_reg = 1'b0;
    full          = '0;

    // timeout on ch1: pulses on cycles 30 and 60
    empty = 3'b101;
    for (int k = 1; k <= 60; k++) begin
      tick();
      check($sformatf("to_ch1_k%0d", k), 32'(soft_reset),
            (k == 30 || k == 60) ? 32'h2 : 32'h0);
    end
    empty = '1;
    tick();
    check("to_ch1_clear", 32'(soft_reset), 32'h0);

    // rescue read on the threshold cycle of ch0
    empty = 3'b110;
    for (int k = 1; k <= 29; k++) begin
      tick();
      check($sformatf("resc_pre_k%0d", k), 32'(soft_reset), 32'h0);
    end
    read_enb = 3'b001;
    tick();
    check("resc_threshold", 32'(soft_reset), 32'h0);
    read_enb = '0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check($sformatf("resc_post_k%0d", k), 32'(soft_reset),
            (k == 30) ? 32'h1 : 32'h0);
    end
    empty = '1;
    tick();

    // simultaneous timeouts on ch0 and ch2, dest 0 writes blocked on the pulse
    write_enb_reg = 1'b1;
    empty         = 3'b010;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check($sformatf("sim_sr_k%0d", k), 32'(soft_reset), (k == 30) ? 32'h5 : 32'h0);
      check($sformatf("sim_we_k%0d", k), 32'(write_enb),  (k == 30) ? 32'h0 : 32'h1);
    end
    empty         = '1;
    write_enb_reg = 1'b0;
    tick();

    // reset mid-stall on ch1
    empty = 3'b101;
    for (int k = 1; k <= 20; k++) tick();
    resetn        = 1'b0;
    write_enb_reg = 1'b1;
    tick();
    check("mid_rst_soft_reset", 32'(soft_reset), 32'h0);
    check("mid_rst_write_enb",  32'(write_enb),  32'h0);
    check("mid_rst_addr_err",   32'(addr_err),   32'h0);
    check("mid_rst_vld_out",    32'(vld_out),    32'h2);
    resetn = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check($sformatf("mid_post_k%0d", k), 32'(soft_reset), (k == 30) ? 32'h2 : 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/router_sync_n.md
ROUTER_SYNC_N -- requirements
Module: router_sync_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of output channels, legal range 2..16.
REQ-002 SHALL have parameter TIMEOUT, default 30, idle-valid cycles before soft reset, legal range 2..1023.
REQ-003 SHALL have parameter ADDR_W, default 2, header address width, at least clog2(NUM_CH).
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  synchronous active-low reset.
REQ-006 SHALL have port detect_add  input  1  header present; latch datain this cycle.
REQ-007 SHALL have port datain  input  ADDR_W  destination address.
REQ-008 SHALL have port write_enb_reg  input  1  FSM request to write the current byte.
REQ-009 SHALL have port read_enb  input  NUM_CH  per-channel consumer read strobe.
REQ-010 SHALL have port empty  input  NUM_CH  per-channel FIFO empty flag.
REQ-011 SHALL have port full  input  NUM_CH  per-channel FIFO full flag.
REQ-012 SHALL have port vld_out  output  NUM_CH  per-channel data-valid flag.
REQ-013 SHALL have port write_enb  output  NUM_CH  one-hot FIFO write enable.
REQ-014 SHALL have port fifo_full  output  1  full flag of the selected destination.
REQ-015 SHALL have port soft_reset  output  NUM_CH  one-cycle per-channel flush pulse.
REQ-016 SHALL have port addr_err  output  1  one-cycle pulse on an out-of-range header address.

Function
REQ-017 SHALL latch datain into dest and set dest_valid=1 on a detect_add cycle with datain<NUM_CH; visible in the next cycle.
REQ-018 SHALL, on a detect_add cycle with datain>=NUM_CH, clear dest_valid and pulse addr_err high for exactly the next cycle.
REQ-019 SHALL hold dest and dest_valid unchanged on cycles without detect_add.
REQ-020 SHALL drive write_enb combinationally: bit dest set only when write_enb_reg=1, dest_valid=1 and soft_reset[dest]=0; all zero otherwise.
REQ-021 SHALL drive fifo_full combinationally: full[dest] when dest_valid=1, else 0.
REQ-022 SHALL drive vld_out[i] combinationally as ~empty[i].
REQ-023 SHALL keep, per channel, a counter cnt[i] of width clog2(TIMEOUT).
REQ-024 SHALL increment cnt[i] on each cycle with vld_out[i]=1 and read_enb[i]=0.
REQ-025 SHALL clear cnt[i] on any cycle with read_enb[i]=1 or vld_out[i]=0.
REQ-026 SHALL, on a stall cycle with cnt[i]==TIMEOUT-1, set cnt[i]=0 and assert soft_reset[i] for exactly the next cycle; first pulse appears TIMEOUT cycles after stall start.
REQ-027 SHALL hold soft_reset[i] low on every other cycle; a continued stall produces a further pulse every TIMEOUT cycles.
REQ-028 SHALL let read_enb[i]=1 on the threshold cycle take priority: counter clears and no pulse is issued.
REQ-029 SHALL keep channels independent; simultaneous timeouts on several channels pulse in the same cycle.
REQ-030 SHALL let detect_add coinciding with soft_reset[dest] latch normally; write gating per REQ-020 uses the new dest only from the next cycle.

Reset
REQ-031 SHALL, when resetn=0 at a clock edge, clear dest, dest_valid, all cnt, soft_reset and addr_err to 0, regardless of other inputs.
REQ-032 SHALL make combinational outputs follow from reset state: write_enb=0 and fifo_full=0; vld_out tracks empty during reset.
REQ-033 SHALL, on reset mid-stall, restart the timeout count from zero after release.

Structure
REQ-034 SHALL take the default NUM_CH, TIMEOUT and ADDR_W constants from shared package router_pkg, which also holds the router header address typedef.
REQ-035 SHALL implement the per-channel counter and pulse as sub-module router_sync_timer, instantiated NUM_CH times in a generate loop.
REQ-036 SHALL contain no latches, and every register SHALL be reset.

Verification
REQ-037 SHALL test address decode: NUM_CH=3, detect_add with datain=2, then write_enb_reg=1 -> write_enb=3'b100 next cycle; fifo_full follows full[2].
REQ-038 SHALL test a bad address: NUM_CH=3, detect_add with datain=3 -> addr_err one-cycle pulse, write_enb=0, fifo_full=0 while write_enb_reg=1.
REQ-039 SHALL test timeout: TIMEOUT=30, empty[1]=0 and read_enb[1]=0 held -> soft_reset[1] high only on cycles 30 and 60 after stall start.
REQ-040 SHALL test a rescue read: stall ch0 29 cycles, then read_enb[0]=1 on the threshold cycle -> no soft_reset[0]; count restarts.
REQ-041 SHALL test simultaneous timeouts: stall ch0 and ch2 starting the same cycle -> soft_reset=3'b101 in one cycle; write_enb to dest 0 blocked that cycle.
REQ-042 SHALL test reset mid-stall: resetn=0 at stall cycle 20 for 1 cycle -> all outputs cleared, next pulse 30 cycles after release.
